// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions used by the pipeline control logic.
package cpu_types_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // Pipeline hazard controller states
   typedef enum logic [1:0] {
      HZ_RUN,
      HZ_MEMWAIT,
      HZ_HALTED
   } hz_state_t;

   // Latch enable / flush strobes, one bundle per cycle
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic exmem_en;
      logic memwb_en;
   } hz_ctrl_t;

   // Full advance: every latch enabled, nothing flushed
   function automatic hz_ctrl_t hz_advance();
      hz_ctrl_t c;
      c            = '0;
      c.pc_en      = 1'b1;
      c.ifid_en    = 1'b1;
      c.idex_en    = 1'b1;
      c.exmem_en   = 1'b1;
      c.memwb_en   = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the hazard controller and the datapath latches.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             ihit;
   logic             dhit;
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             ifid_uses_rt;
   logic             idex_dREN;
   logic [4:0]       idex_wsel;
   logic             exmem_dREN;
   logic             exmem_dWEN;
   logic             redirect_ex;
   logic             halt_wb;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_flush;
   logic             exmem_en;
   logic             memwb_en;
   logic             halted;
   logic [CNT_W-1:0] stall_count;

   modport hc (
      input  ihit, dhit, ifid_rs, ifid_rt, ifid_uses_rt, idex_dREN, idex_wsel,
             exmem_dREN, exmem_dWEN, redirect_ex, halt_wb,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             memwb_en, halted, stall_count
   );

   modport dp (
      output ihit, dhit, ifid_rs, ifid_rt, ifid_uses_rt, idex_dREN, idex_wsel,
             exmem_dREN, exmem_dWEN, redirect_ex, halt_wb,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
             memwb_en, halted, stall_count
   );

endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline control: latch enables/flushes, load-use bubbles, miss freezes,
// redirect flushes (held across fetch stalls) and halt retirement.
module hazard_ctrl
   import cpu_types_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             idex_dREN,
   input  logic [4:0]       idex_wsel,
   input  logic             exmem_dREN,
   input  logic             exmem_dWEN,
   input  logic             redirect_ex,
   input  logic             halt_wb,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count
);

   hz_state_t        state, state_n;
   logic             redir_pend, redir_pend_n;
   logic             halted_q;
   logic [CNT_W-1:0] cnt_q;
   hz_ctrl_t         ctrl;
   logic             mem_busy;
   logic             load_use;
   logic             redir;

   // Hazard conditions seen this cycle
   always_comb begin
      mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;
      load_use = idex_dREN & (idex_wsel != REG_ZERO) &
                 ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt)));
      redir    = redirect_ex | redir_pend;
   end

   // State, pending-redirect and halt flag registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= HZ_RUN;
         redir_pend <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state      <= state_n;
         redir_pend <= redir_pend_n;
         halted_q   <= (state_n == HZ_HALTED);
      end
   end

   // Next state and latch strobes; a miss cycle that completes (dhit) falls
   // through to the normal RUN rules
   always_comb begin
      state_n      = state;
      redir_pend_n = redir_pend;
      ctrl         = '0;
      unique case (state)
         HZ_HALTED: begin
            state_n = HZ_HALTED;
         end
         default: begin
            if (mem_busy) begin
               state_n = HZ_MEMWAIT;
            end else begin
               state_n = HZ_RUN;
               if (!ihit) begin
                  if (redirect_ex) redir_pend_n = 1'b1;
               end else if (redir) begin
                  ctrl            = hz_advance();
                  ctrl.ifid_flush = 1'b1;
                  ctrl.idex_flush = 1'b1;
                  redir_pend_n    = 1'b0;
               end else if (load_use) begin
                  ctrl            = hz_advance();
                  ctrl.pc_en      = 1'b0;
                  ctrl.ifid_en    = 1'b0;
                  ctrl.idex_flush = 1'b1;
               end else begin
                  ctrl = hz_advance();
               end
            end
            if (halt_wb) state_n = HZ_HALTED;
         end
      endcase
   end

   // Saturating count of cycles where the PC did not advance
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q <= '0;
      end else if ((state != HZ_HALTED) && !ctrl.pc_en && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign pc_en       = ctrl.pc_en;
   assign ifid_en     = ctrl.ifid_en;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_en     = ctrl.idex_en;
   assign idex_flush  = ctrl.idex_flush;
   assign exmem_en    = ctrl.exmem_en;
   assign memwb_en    = ctrl.memwb_en;
   assign halted      = halted_q;
   assign stall_count = cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block for the 5-stage MIPS core.
- Generates the enable and flush strobes consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB latches, and the PC write enable.
- Detects load-use hazards, cache-miss freezes, EX-stage control redirects and halt retirement.
- Holds a redirect that arrives while fetch is stalled, so the wrong-path flush is never lost.

Parameters:
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
ihit  in  1  instruction fetch completes this cycle
dhit  in  1  data access completes this cycle
ifid_rs  in  5  rs field of instruction in ID
ifid_rt  in  5  rt field of instruction in ID
ifid_uses_rt  in  1  ID instruction reads rt as a source
idex_dREN  in  1  instruction in EX is a load (incl. LL)
idex_wsel  in  5  destination register of instruction in EX
exmem_dREN  in  1  MEM-stage read request
exmem_dWEN  in  1  MEM-stage write request (incl. SC)
redirect_ex  in  1  taken branch / jump / JR resolved in EX
halt_wb  in  1  HALT instruction is in WB
pc_en  out  1  PC register write enable
ifid_en  out  1  IF/ID latch enable
ifid_flush  out  1  IF/ID flush (valid only with ifid_en)
idex_en  out  1  ID/EX latch enable (drives its iHit input)
idex_flush  out  1  ID/EX flush (drives its flush input)
exmem_en  out  1  EX/MEM latch enable
memwb_en  out  1  MEM/WB latch enable
halted  out  1  core halted, sticky
stall_count  out  CNT_W  saturating count of cycles with pc_en=0 before halt

Behaviour:
- Reset is decided: nRST asynchronous, active-low; clock CLK.
- Reset values:
  - state=RUN, redir_pend=0, stall_count=0, halted=0.
  - All enables and flushes are combinational, so they evaluate with state=RUN after reset.
- States:
  - RUN: normal operation.
  - MEMWAIT: data access outstanding.
  - HALTED: terminal until reset.
- mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit.
- load_use = idex_dREN & (idex_wsel != 0) & ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt))).
- redir = redirect_ex | redir_pend.
- Priority per cycle: halt > mem_busy > ~ihit > redirect > load_use > normal.
- HALTED:
  - All enables 0, flushes 0, halted=1, stall_count frozen.
  - Entered the cycle after halt_wb=1 in any state.
- mem_busy (in RUN or MEMWAIT): all enables 0, all flushes 0. Next state is MEMWAIT.
- MEMWAIT -> RUN: on the first cycle with dhit=1. That cycle evaluates as RUN rules using the current ihit.
- RUN with ihit=0:
  - All enables 0.
  - If redirect_ex=1, set redir_pend<=1.
- RUN, ihit=1, redir=1:
  - pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1.
  - redir_pend<=0.
  - Redirect overrides load_use, because the load-use consumer is wrong-path.
- RUN, ihit=1, load_use=1:
  - pc_en=0, ifid_en=0, idex_en=1, idex_flush=1 (bubble), exmem_en=1, memwb_en=1.
  - Exactly one bubble per load-use pair, because the next cycle idex_dREN=0.
- RUN, ihit=1, otherwise: all enables 1, flushes 0.
- Redirect timing:
  - redir_pend is set only while redirect_ex=1 and no advance occurs.
  - Because EX is frozen, redirect_ex stays asserted; redir_pend covers EX-side source deassertion.
  - When redir_pend=1 and mem_busy=1, redir_pend holds.
- stall_count:
  - Increments by 1 on each cycle with pc_en=0 and state != HALTED.
  - Saturates at 2^CNT_W-1, no wrap.
- Reset mid-operation:
  - Asynchronous return to RUN.
  - Clears redir_pend, stall_count and halted on the same edge.

Decomposition:
- Add to cpu_types_pkg: typedef enum logic[1:0] {HZ_RUN, HZ_MEMWAIT, HZ_HALTED} hz_state_t.
- Add to cpu_types_pkg: localparam REG_ZERO = 5'd0.
- Add a hazard_ctrl_if interface with modports for hazard_ctrl and the datapath, matching the latch interface style.
- No sub-module is needed. The stall counter is inline.

Test Plan:
- Load-use, rs path: idex_dREN=1, idex_wsel=8, ifid_rs=8, ihit=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1. Next cycle all enables 1. stall_count=1.
- $zero load: idex_dREN=1, idex_wsel=0, ifid_rs=0 -> no stall. All enables 1.
- Cache miss: exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of all enables 0 in MEMWAIT, then RUN with full advance. stall_count=3.
- Redirect during fetch miss:
  - redirect_ex=1 with ihit=0 for 2 cycles -> enables 0, redir_pend=1.
  - Then ihit=1 -> ifid_flush=1 and idex_flush=1 for one cycle, redir_pend=0.
- Redirect plus load-use in the same cycle with ihit=1 -> flush path taken, pc_en=1, no extra bubble.
- Halt:
  - halt_wb=1 -> from the next cycle, halted=1 and all enables 0 permanently. stall_count stops.
  - nRST pulse mid-halt -> halted=0, stall_count=0.
